// File: rtl/sram2_master.sv
// Single-word request initiator for the SRAM2 window: decodes range/alignment,
// adds per-byte even parity on writes, and returns read data or an error code.
module sram2_master #(
  parameter logic [15:0] BASE_HI    = 16'h1000,
  parameter int unsigned SPAN_BYTES = 32768,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic [7:0]  err_count,
  output logic [31:0] mem_addr,
  output logic [35:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  input  logic        mem_perr
);

  localparam int unsigned   CW       = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          wr_q;
  logic [CW-1:0] cnt;
  logic [1:0]    dec_err;
  logic [3:0]    wpar;

  // Out-of-window takes priority over misalignment.
  always_comb begin
    dec_err = 2'b00;
    if (req_addr[31:16] != BASE_HI || 32'(req_addr[15:0]) >= SPAN_BYTES)
      dec_err = 2'b01;
    else if (req_addr[1:0] != 2'b00)
      dec_err = 2'b11;
  end

  always_comb begin
    wpar = '0;
    for (int unsigned n = 0; n < 4; n++)
      wpar[n] = ^req_wdata[8*n +: 8];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (req_valid) state_next = (dec_err != 2'b00) ? RESP : ISSUE;
      ISSUE: state_next = wr_q ? RESP : WAIT;
      WAIT:  if (cnt == '0) state_next = RESP;
      RESP:  if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // mem_we is decoded from state so an async reset drops it without a clock edge.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE:    req_ready  = 1'b1;
      ISSUE:   mem_we     = wr_q;
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q       <= 1'b0;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_err   <= '0;
      err_count  <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q       <= req_write;
            resp_rdata <= '0;
            resp_err   <= dec_err;
            if (dec_err == 2'b00) begin
              mem_addr  <= {BASE_HI, 2'b00, req_addr[15:2]};
              mem_wdata <= req_write ? {wpar, req_wdata} : '0;
            end
          end
        end
        ISSUE: begin
          cnt <= CNT_LOAD;
          if (wr_q && mem_perr) resp_err <= 2'b10;
        end
        WAIT: begin
          if (cnt == '0) resp_rdata <= mem_rdata;
          else           cnt        <= cnt - 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= '0;
            if (resp_err != 2'b00 && err_count != 8'hFF)
              err_count <= err_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
